// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: FSM state encoding and
// the port indices used by the round-robin logic and the `last` register.
package data_memory_arbiter_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      LOCKED1 = 1'b1
   } arb_state_e;

   localparam logic CPU_PORT    = 1'b0;
   localparam logic LOADER_PORT = 1'b1;

endpackage

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// (port 0) and the program/debug loader (port 1), with a loader lock.
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata1,
   input  logic                  lock1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_write_enable,
   output logic [DATA_WIDTH-1:0] mem_data_in,
   input  logic [DATA_WIDTH-1:0] mem_data_out
);

   arb_state_e state;
   logic       last;
   logic [1:0] rd_owner;

   // On a tie the port that was not granted most recently wins.
   function automatic logic rr_pick(input logic r0, input logic r1, input logic prev);
      if (r0 && r1) begin
         return ~prev;
      end else if (r1) begin
         return LOADER_PORT;
      end else begin
         return CPU_PORT;
      end
   endfunction

   // Grants are combinational so a request is accepted in its own cycle;
   // reset suppresses them so the memory is never touched while resetting.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (state == LOCKED1) begin
            gnt1 = req1;
         end else if (req0 || req1) begin
            if (rr_pick(req0, req1, last) == LOADER_PORT) begin
               gnt1 = 1'b1;
            end else begin
               gnt0 = 1'b1;
            end
         end
      end
   end

   always_comb begin
      mem_address      = gnt1 ? addr1  : addr0;
      mem_data_in      = gnt1 ? wdata1 : wdata0;
      mem_write_enable = (gnt1 & we1) | (gnt0 & we0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last     <= LOADER_PORT;
         rd_owner <= 2'b00;
      end else begin
         rd_owner <= {gnt1 & ~we1, gnt0 & ~we0};
         if (gnt0) begin
            last <= CPU_PORT;
         end else if (gnt1) begin
            last <= LOADER_PORT;
         end
         if (state == IDLE) begin
            if (gnt1 && lock1) begin
               state <= LOCKED1;
            end
         end else if (!lock1) begin
            state <= IDLE;
         end
      end
   end

   // A read granted just before reset must not report data during reset.
   assign rvalid0 = rd_owner[0] & ~rst;
   assign rvalid1 = rd_owner[1] & ~rst;
   assign rdata0  = mem_data_out;
   assign rdata1  = mem_data_out;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: behavioral memory, reference
// copy of memory contents and per-port read scoreboards.
module tb_data_memory_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0, we0, req1, we1, lock1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] mem_address;
   logic          mem_write_enable;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out = '0;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          q0[$];
   exp_t          q1[$];
   logic [DW-1:0] mem     [0:63];
   logic [DW-1:0] ref_mem [0:63];
   logic          mem_ready = 1'b0;
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   logic          m_last;

   data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .lock1(lock1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_address(mem_address), .mem_write_enable(mem_write_enable),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   function automatic logic [DW-1:0] init_word(input int i);
      return 32'hA5A5_0000 + 32'(i);
   endfunction

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port synchronous memory; a write cycle leaves data_out untouched.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
         mem_ready <= 1'b1;
      end else if (mem_write_enable) begin
         mem[mem_address[5:0]] <= mem_data_in;
      end else begin
         mem_data_out <= mem[mem_address[5:0]];
      end
   end

   task automatic set_ports(input logic r0, input logic w0, input logic [AW-1:0] a0,
                            input logic [DW-1:0] d0, input logic r1, input logic w1,
                            input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                            input logic l1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      lock1 = l1;
   endtask

   task automatic push0(input logic [DW-1:0] d);
      exp_t e;
      e.due  = cyc + 1;
      e.data = d;
      q0.push_back(e);
   endtask

   task automatic push1(input logic [DW-1:0] d);
      exp_t e;
      e.due  = cyc + 1;
      e.data = d;
      q1.push_back(e);
   endtask

   // Move to mid-cycle and retire any read results due this cycle.
   task automatic settle();
      @(negedge clk);
      total++;
      if (q0.size() != 0 && q0[0].due <= cyc) begin
         if (rvalid0 !== 1'b1 || rdata0 !== q0[0].data) begin
            bad++;
            $display("[TB] FAIL read0 cyc=%0d rvalid0=%b rdata0=%h expected rvalid0=1 rdata0=%h",
                     cyc, rvalid0, rdata0, q0[0].data);
         end
         void'(q0.pop_front());
      end else if (rvalid0 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL idle0 cyc=%0d rvalid0=%b expected 0", cyc, rvalid0);
      end
      total++;
      if (q1.size() != 0 && q1[0].due <= cyc) begin
         if (rvalid1 !== 1'b1 || rdata1 !== q1[0].data) begin
            bad++;
            $display("[TB] FAIL read1 cyc=%0d rvalid1=%b rdata1=%h expected rvalid1=1 rdata1=%h",
                     cyc, rvalid1, rdata1, q1[0].data);
         end
         void'(q1.pop_front());
      end else if (rvalid1 !== 1'b0) begin
         bad++;
         $display("[TB] FAIL idle1 cyc=%0d rvalid1=%b expected 0", cyc, rvalid1);
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_ports(1, 1, 3, 32'h1, 1, 1, 4, 32'h2, 1);
      for (int k = 0; k < 2; k++) begin
         settle();
         total++;
         if ({gnt0, gnt1, mem_write_enable} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL reset_outputs gnt0,gnt1,we=%b expected 000",
                     {gnt0, gnt1, mem_write_enable});
         end
         advance();
      end
      rst = 1'b0;
      set_ports(0, 0, 0, 0, 0, 0, 0, 0, 0);
      m_last = 1'b1;
      settle();
      advance();
   endtask

   task automatic test_alternate();
      logic w;
      for (int k = 0; k < 4; k++) begin
         set_ports(1, 0, AW'(10 + k), 0, 1, 0, AW'(20 + k), 0, 0);
         settle();
         w = ~m_last;
         total++;
         if ({gnt0, gnt1} !== (w ? 2'b01 : 2'b10) || mem_address !== (w ? addr1 : addr0)) begin
            bad++;
            $display("[TB] FAIL alternate beat=%0d gnt0,gnt1=%b addr=%0d expected winner port %0d",
                     k, {gnt0, gnt1}, mem_address, w);
         end
         if (w) push1(ref_mem[20 + k]);
         else   push0(ref_mem[10 + k]);
         m_last = w;
         advance();
      end
      set_ports(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      advance();
   endtask

   task automatic test_single_read();
      set_ports(1, 0, 3, 0, 0, 0, 0, 0, 0);
      settle();
      total++;
      if ({gnt0, gnt1} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL single_read gnt0,gnt1=%b expected 10", {gnt0, gnt1});
      end
      push0(ref_mem[3]);
      m_last = 1'b0;
      advance();
      set_ports(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      advance();
   endtask

   task automatic test_lock();
      for (int k = 0; k < 3; k++) begin
         set_ports(1, 0, 4, 0, 1, 1, 2, 32'hDEADBEEF, 1);
         settle();
         total++;
         if ({gnt0, gnt1} !== 2'b01 || mem_write_enable !== 1'b1 ||
             mem_address !== 2 || mem_data_in !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL lock_beat=%0d gnt0,gnt1=%b we=%b addr=%0d din=%h expected 01 1 2 deadbeef",
                     k, {gnt0, gnt1}, mem_write_enable, mem_address, mem_data_in);
         end
         ref_mem[2] = 32'hDEADBEEF;
         m_last = 1'b1;
         advance();
      end
      set_ports(1, 0, 4, 0, 0, 0, 0, 0, 0);
      settle();
      total++;
      if ({gnt0, gnt1, mem_write_enable} !== 3'b000) begin
         bad++;
         $display("[TB] FAIL lock_release gnt0,gnt1,we=%b expected 000", {gnt0, gnt1, mem_write_enable});
      end
      advance();
      settle();
      total++;
      if ({gnt0, gnt1} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL lock_after gnt0,gnt1=%b expected 10", {gnt0, gnt1});
      end
      push0(ref_mem[4]);
      m_last = 1'b0;
      advance();
      set_ports(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      advance();
   endtask

   task automatic test_write_then_read();
      set_ports(1, 1, 5, 32'h12345678, 0, 0, 0, 0, 0);
      settle();
      total++;
      if ({gnt0, gnt1} !== 2'b10 || mem_write_enable !== 1'b1) begin
         bad++;
         $display("[TB] FAIL write0 gnt0,gnt1=%b we=%b expected 10 1", {gnt0, gnt1}, mem_write_enable);
      end
      ref_mem[5] = 32'h12345678;
      m_last = 1'b0;
      advance();
      set_ports(0, 0, 0, 0, 1, 0, 5, 0, 0);
      settle();
      total++;
      if ({gnt0, gnt1} !== 2'b01 || mem_write_enable !== 1'b0) begin
         bad++;
         $display("[TB] FAIL read1_after_write gnt0,gnt1=%b we=%b expected 01 0",
                  {gnt0, gnt1}, mem_write_enable);
      end
      push1(ref_mem[5]);
      m_last = 1'b1;
      advance();
      set_ports(0, 0, 0, 0, 1, 0, 2, 0, 0);
      settle();
      total++;
      if ({gnt0, gnt1} !== 2'b01) begin
         bad++;
         $display("[TB] FAIL read1_addr2 gnt0,gnt1=%b expected 01", {gnt0, gnt1});
      end
      push1(ref_mem[2]);
      advance();
      set_ports(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      advance();
   endtask

   task automatic test_reset_mid_read();
      set_ports(0, 0, 0, 0, 1, 0, 8, 0, 1);
      settle();
      total++;
      if ({gnt0, gnt1} !== 2'b01) begin
         bad++;
         $display("[TB] FAIL lock_enter gnt0,gnt1=%b expected 01", {gnt0, gnt1});
      end
      push1(ref_mem[8]);
      advance();
      set_ports(1, 0, 7, 0, 0, 0, 0, 0, 1);
      settle();
      total++;
      if ({gnt0, gnt1} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL lock_holdoff gnt0,gnt1=%b expected 00", {gnt0, gnt1});
      end
      advance();
      rst = 1'b1;
      settle();
      advance();
      rst = 1'b0;
      m_last = 1'b1;
      set_ports(1, 0, 7, 0, 0, 0, 0, 0, 0);
      settle();
      total++;
      if ({gnt0, gnt1} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL lock_cleared_by_reset gnt0,gnt1=%b expected 10", {gnt0, gnt1});
      end
      push0(ref_mem[7]);
      m_last = 1'b0;
      advance();
      set_ports(1, 0, 6, 0, 0, 0, 0, 0, 0);
      settle();
      total++;
      if ({gnt0, gnt1} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL read_before_reset gnt0,gnt1=%b expected 10", {gnt0, gnt1});
      end
      advance();
      rst = 1'b1;
      set_ports(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      total++;
      if (rvalid0 !== 1'b0 || {gnt0, gnt1} !== 2'b00) begin
         bad++;
         $display("[TB] FAIL rvalid_killed rvalid0=%b gnt0,gnt1=%b expected 0 00", rvalid0, {gnt0, gnt1});
      end
      advance();
      rst = 1'b0;
      m_last = 1'b1;
      set_ports(1, 0, 1, 0, 1, 0, 1, 0, 0);
      settle();
      total++;
      if ({gnt0, gnt1} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL tie_after_reset gnt0,gnt1=%b expected 10", {gnt0, gnt1});
      end
      push0(ref_mem[1]);
      advance();
      settle();
      total++;
      if ({gnt0, gnt1} !== 2'b01) begin
         bad++;
         $display("[TB] FAIL tie_second gnt0,gnt1=%b expected 01", {gnt0, gnt1});
      end
      push1(ref_mem[1]);
      m_last = 1'b1;
      advance();
      set_ports(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      advance();
   endtask

   task automatic test_locked_idle();
      set_ports(0, 0, 0, 0, 1, 1, 9, 32'hCAFEF00D, 1);
      settle();
      total++;
      if ({gnt0, gnt1} !== 2'b01 || mem_write_enable !== 1'b1) begin
         bad++;
         $display("[TB] FAIL locked_write gnt0,gnt1=%b we=%b expected 01 1", {gnt0, gnt1}, mem_write_enable);
      end
      ref_mem[9] = 32'hCAFEF00D;
      m_last = 1'b1;
      advance();
      for (int k = 0; k < 2; k++) begin
         set_ports(1, 0, 9, 0, 0, 0, 0, 0, 1);
         settle();
         total++;
         if ({gnt0, gnt1, mem_write_enable} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL locked_idle cycle=%0d gnt0,gnt1,we=%b expected 000",
                     k, {gnt0, gnt1, mem_write_enable});
         end
         advance();
      end
      set_ports(1, 0, 9, 0, 0, 0, 0, 0, 0);
      settle();
      total++;
      if ({gnt0, gnt1, mem_write_enable} !== 3'b000) begin
         bad++;
         $display("[TB] FAIL locked_drop gnt0,gnt1,we=%b expected 000", {gnt0, gnt1, mem_write_enable});
      end
      advance();
      settle();
      total++;
      if ({gnt0, gnt1} !== 2'b10) begin
         bad++;
         $display("[TB] FAIL locked_pending gnt0,gnt1=%b expected 10", {gnt0, gnt1});
      end
      push0(ref_mem[9]);
      m_last = 1'b0;
      advance();
      set_ports(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle();
      advance();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
      m_last = 1'b1;
      set_ports(0, 0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_alternate();
      test_single_read();
      test_lock();
      test_write_then_read();
      test_reset_mid_read();
      test_locked_idle();
      settle();
      total++;
      if (q0.size() != 0 || q1.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain pending0=%0d pending1=%0d expected 0 0", q0.size(), q1.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
